// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: oversamples SCK/CS/SI on CLK, decodes wake-up (0xAB)
// and read (0x03) commands, then streams bytes from an external synchronous byte memory.
// Optional feature: define SPI_RESP_FAST_READ_EN to accept fast read (0x0B, 8 dummy clocks).
module spi_flash_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 24
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              SPI_CS,
    input  logic              SPI_SCK,
    input  logic              SPI_SI,
    output logic              SPI_SO,
    output logic              SPI_SO_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              awake,
    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
`ifdef SPI_RESP_FAST_READ_EN
        StDummy,
`endif
        StData,
        StIgnore
    } state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, si_sync_q;
    logic                   sck_prev_q;
    logic                   sck_s, cs_s, si_s, sck_rise, sck_fall;

    state_e              state_q, state_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-2:0]   shift_q, shift_d;
    logic [7:0]          so_shift_q, so_shift_d;
    logic                so_q, so_d;
    logic                so_oe_q, so_oe_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                awake_q, awake_d;
    logic                load_q;
    logic [7:0]          opcode;
    logic [ADDR_W-1:0]   addr_full;
`ifdef SPI_RESP_FAST_READ_EN
    logic                fast_q, fast_d;
`endif

    // Synchronize the SPI inputs and keep the previous SCK sample for edge detection.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            si_sync_q  <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
            si_sync_q  <= {si_sync_q[SYNC_STAGES-2:0], SPI_SI};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign si_s      = si_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign opcode    = {shift_q[6:0], si_s};
    assign addr_full = {shift_q, si_s};

    // Next-state logic: protocol FSM, shift registers and memory request generation.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        so_shift_d = so_shift_q;
        so_d       = so_q;
        so_oe_d    = so_oe_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        awake_d    = awake_q;
`ifdef SPI_RESP_FAST_READ_EN
        fast_d     = fast_q;
`endif

        // Byte requested last cycle is on mem_rdata now.
        if (load_q) begin
            so_shift_d = mem_rdata;
        end

        if (cs_s && state_q != StIdle) begin
            // CS deassertion wins over any coincident SCK edge.
            state_d   = StIdle;
            so_oe_d   = 1'b0;
            so_d      = 1'b1;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    bit_cnt_d = '0;
                    so_oe_d   = 1'b0;
                    so_d      = 1'b1;
                    if (!cs_s) begin
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        shift_d   = {shift_q[ADDR_W-3:0], si_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            state_d   = StIgnore;
                            if (opcode == 8'hAB) begin
                                awake_d = 1'b1;
                            end else if (opcode == 8'h03 && awake_q) begin
                                state_d = StAddr;
`ifdef SPI_RESP_FAST_READ_EN
                                fast_d  = 1'b0;
                            end else if (opcode == 8'h0B && awake_q) begin
                                state_d = StAddr;
                                fast_d  = 1'b1;
`endif
                            end
                        end
                    end
                end
                StAddr: begin
                    if (sck_rise) begin
                        shift_d   = {shift_q[ADDR_W-3:0], si_s};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d  = '0;
                            mem_addr_d = addr_full;
`ifdef SPI_RESP_FAST_READ_EN
                            if (fast_q) begin
                                state_d = StDummy;
                            end else begin
                                mem_rd_d = 1'b1;
                                state_d  = StData;
                            end
`else
                            mem_rd_d = 1'b1;
                            state_d  = StData;
`endif
                        end
                    end
                end
`ifdef SPI_RESP_FAST_READ_EN
                StDummy: begin
                    // SO stays released; the first read goes out on the last dummy rise.
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            mem_rd_d  = 1'b1;
                            state_d   = StData;
                        end
                    end
                end
`endif
                StData: begin
                    if (sck_fall) begin
                        so_oe_d    = 1'b1;
                        so_d       = so_shift_q[7];
                        so_shift_d = {so_shift_q[6:0], 1'b0};
                    end else if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d  = '0;
                            mem_rd_d   = 1'b1;
                            mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                StIgnore: begin
                    so_oe_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            so_shift_q <= '0;
            so_q       <= 1'b1;
            so_oe_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            awake_q    <= 1'b0;
            load_q     <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
            fast_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            so_shift_q <= so_shift_d;
            so_q       <= so_d;
            so_oe_q    <= so_oe_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            awake_q    <= awake_d;
            load_q     <= mem_rd_q;
`ifdef SPI_RESP_FAST_READ_EN
            fast_q     <= fast_d;
`endif
        end
    end

    assign SPI_SO    = so_q;
    assign SPI_SO_oe = so_oe_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign awake     = awake_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI mode-0 flash responder: the target side of the flash read protocol issued by the CPU's SPI controller.
- Oversamples SPI_SCK/SPI_CS/SPI_SI on the system clock.
- Decodes wake-up (0xAB) and read (0x03) commands, then streams bytes from an external synchronous byte memory.
- Used as an on-FPGA / simulation flash replacement so the cache-miss path can be exercised without the physical flash.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on SPI_SCK, SPI_CS and SPI_SI (min 2).
- ADDR_W, 24, address width assembled from the command; fixed at 24 by protocol, exposed only for mem_addr sizing.

Ports:
- CLK  input  1  system clock; must run at least 8x SPI_SCK, with SCK high and low phases each at least 4 CLK.
- resetn  input  1  asynchronous active-low reset.
- SPI_CS  input  1  chip select, active low.
- SPI_SCK  input  1  serial clock from the initiator.
- SPI_SI  input  1  serial data in, MSB first.
- SPI_SO  output  1  serial data out, MSB first.
- SPI_SO_oe  output  1  1 = SPI_SO driven; 0 = released.
- mem_rd  output  1  single-cycle byte read strobe.
- mem_addr  output  24  byte address for mem_rd.
- mem_rdata  input  8  byte data, valid exactly 1 CLK after mem_rd.
- awake  output  1  1 after a valid 0xAB command.
- busy  output  1  1 while a transaction is in progress (CS low, any state other than IDLE).

Behaviour:
- Reset values: SPI_SO=1, SPI_SO_oe=0, mem_rd=0, mem_addr=0, awake=0, busy=0, FSM=IDLE, all counters 0.
- Input sampling:
  - SCK, CS and SI pass through SYNC_STAGES flops.
  - Rise/fall events come from comparing the last two synchronized SCK samples.
  - SI is captured on a synchronized SCK rise.
  - SO changes only on a synchronized SCK fall.
- FSM states: IDLE, CMD, ADDR, DATA, IGNORE.
- IDLE: CS low -> CMD; bit counter cleared.
- CMD: shift 8 bits on SCK rises. On the 8th bit:
  - 0x03 with awake=1 -> ADDR.
  - 0x03 with awake=0 -> IGNORE.
  - 0xAB -> awake<=1, then IGNORE; any extra clocks are ignored.
  - Any other opcode -> IGNORE.
- ADDR: shift 24 bits MSB first. On the 24th rise, in the same CLK as the event:
  - mem_rd<=1 and mem_addr<=assembled address.
  - One CLK later, load the SO shift register from mem_rdata.
  - Go to DATA.
- DATA:
  - First SCK fall after entering DATA: SPI_SO_oe<=1, SPI_SO<=bit7.
  - Each following fall shifts out the next bit.
  - On the SCK rise that completes bit 0 of a byte: pulse mem_rd with mem_addr+1, and load the new byte before the next fall.
  - Streaming continues until CS rises.
  - Address wraps 0xFFFFFF -> 0x000000.
- IGNORE: SO_oe=0, no memory reads; wait for CS high.
- CS high in any state, including mid-byte: next CLK returns to IDLE, SPI_SO_oe<=0, SPI_SO<=1, counters cleared, no mem_rd. A partial command or address is discarded.
- SCK edges while CS is high are ignored.
- awake is cleared only by reset.
- A simultaneous CS rise and SCK edge: the CS rise wins; the edge is ignored.
- mem_rd is never asserted on two consecutive CLKs.

Optional Feature:
- Macro: SPI_RESP_FAST_READ_EN.
- Defined: opcode 0x0B is accepted when awake. It follows the 0x03 flow, but after the 24 address bits it counts 8 dummy SCK rises with SO_oe=0. The first mem_rd is issued on the 8th dummy rise, and the first data bit is driven on the following fall.
- Undefined: 0x0B is treated as an unknown opcode and goes to IGNORE.

Test Plan:
- Reset, then CS low, send 0x03 + address 0x051000 -> no mem_rd, SPI_SO_oe stays 0, awake=0.
- Send 0xAB, raise CS, then 0x03 + 0x051000, 32 clocks, with the memory model byte[a]=a[7:0]^0x5A -> mem_addr sequence 0x051000..0x051003; SO bytes 0x5A,0x5B,0x58,0x59; first data bit driven on the fall after the 24th address rise.
- Awake, read at 0xFFFFFF for 16 clocks -> mem_addr 0xFFFFFF then 0x000000; SO carries both bytes.
- Awake, raise CS after 13 address bits, then a new 0x03 + 0x000010 -> the first transaction produces no mem_rd; the second reads 0x000010 correctly.
- Opcode 0x9F while awake -> IGNORE, SO_oe=0 for the whole CS-low period, busy=1 until CS high, then busy=0.
- With SPI_RESP_FAST_READ_EN: 0x0B + 0x000020 + 8 dummy clocks -> SO_oe=0 during the dummy clocks, then byte[0x20] is output. Without the macro -> IGNORE.
